// File: rtl/fusion_array_stream_pkg.sv
// Shared types for the weight-stationary fusion array: FSM states, latched
// precision config and the operand sign/width extension used by every unit.
package fusion_array_pkg;

    localparam int unsigned ROWS_DEF   = 8;
    localparam int unsigned COLS_DEF   = 8;
    localparam int unsigned PSUM_W_DEF = 52;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] in_width;
        logic [3:0] weight_width;
        logic       s_in;
        logic       s_weight;
    } cfg_t;

    // Keep the low 'w' bits of an 8-bit lane and extend them to 9 bits signed.
    function automatic logic signed [8:0] ext_operand(input logic [7:0] v,
                                                      input logic [3:0] w,
                                                      input logic       s);
        logic signed [8:0] r;
        case (w)
            4'd1:    r = {{8{s & v[0]}}, v[0]};
            4'd2:    r = {{7{s & v[1]}}, v[1:0]};
            4'd4:    r = {{5{s & v[3]}}, v[3:0]};
            default: r = {s & v[7], v};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fusion_array_stream_input_skew.sv
// Triangular activation skew (row i delayed i+1 cycles, input register
// included) and the valid/last pipe aligned to the psum wavefront.
module input_skew #(
    parameter int unsigned ROWS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_i,
    input  logic              last_i,
    input  logic [ROWS*8-1:0] data_i,
    output logic [ROWS*8-1:0] row_data_o,
    output logic              valid_o,
    output logic              last_o
);

    // Input register + ROWS grid stages + output psum register.
    localparam int unsigned PIPE_D = ROWS + 2;

    logic [PIPE_D-1:0] vld_q;
    logic [PIPE_D-1:0] lst_q;

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        logic [7:0] dl_q [i+1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= i; k++) dl_q[k] <= 8'd0;
            end else begin
                dl_q[0] <= acc_i ? data_i[8*i +: 8] : 8'd0;
                for (int k = 1; k <= i; k++) dl_q[k] <= dl_q[k-1];
            end
        end

        assign row_data_o[8*i +: 8] = dl_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q <= {vld_q[PIPE_D-2:0], acc_i};
            lst_q <= {lst_q[PIPE_D-2:0], acc_i & last_i};
        end
    end

    assign valid_o = vld_q[PIPE_D-1];
    assign last_o  = lst_q[PIPE_D-1];

endmodule

// File: rtl/fusion_unit.sv
// One processing element: psum_fwd <= psum_in + in*weight at the latched
// precision, full PSUM_W width, wrapping modulo 2^PSUM_W.
module fusion_unit
    import fusion_array_pkg::*;
#(
    parameter int unsigned PSUM_W = PSUM_W_DEF
) (
    input  logic              clk,
    input  logic [7:0]        in_data,
    input  logic [7:0]        weight,
    input  logic [3:0]        in_width,
    input  logic [3:0]        weight_width,
    input  logic              s_in,
    input  logic              s_weight,
    input  logic [PSUM_W-1:0] psum_in,
    output logic [PSUM_W-1:0] psum_fwd
);

    logic signed [8:0]        a_op;
    logic signed [8:0]        b_op;
    logic signed [17:0]       prod;
    logic signed [PSUM_W-1:0] prod_ext;

    always_comb begin
        a_op     = ext_operand(in_data, in_width, s_in);
        b_op     = ext_operand(weight, weight_width, s_weight);
        prod     = 18'(a_op) * 18'(b_op);
        prod_ext = PSUM_W'(prod);
    end

    // Not reset: stale sums are masked by the valid pipe.
    always_ff @(posedge clk) begin
        psum_fwd <= psum_in + prod_ext;
    end

endmodule

// File: rtl/fusion_array_stream.sv
// Weight-stationary ROWS x COLS fusion array with handshaked weight preload,
// internal input skew and a valid/last pipe aligned to the column sums.
module fusion_array_stream
    import fusion_array_pkg::*;
#(
    parameter int unsigned ROWS   = ROWS_DEF,
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned PSUM_W = PSUM_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             in_width,
    input  logic [3:0]             weight_width,
    input  logic                   s_in,
    input  logic                   s_weight,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [COLS*8-1:0]      w_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [ROWS*8-1:0]      in_data,
    output logic                   out_valid,
    output logic                   out_last,
    output logic [COLS*PSUM_W-1:0] psums,
    output logic                   busy
);

    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned DW = $clog2(ROWS + 1);

    state_e                 state_q;
    logic                   loaded_q;
    logic [RW-1:0]          row_q;
    logic [DW-1:0]          drain_q;
    cfg_t                   cfg_q;
    logic [COLS*8-1:0]      w_q [ROWS];
    logic [COLS*PSUM_W-1:0] psums_q;
    logic [ROWS*8-1:0]      row_data;
    logic [PSUM_W-1:0]      psum_w [ROWS][COLS];
    logic                   w_acc;
    logic                   in_acc;

    // Handshake decode; a weight beat in IDLE wins over a simultaneous vector.
    always_comb begin
        w_ready  = 1'b0;
        in_ready = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            IDLE:    begin
                w_ready  = 1'b1;
                in_ready = loaded_q & ~w_valid;
            end
            LOAD_W:  w_ready  = 1'b1;
            STREAM:  in_ready = 1'b1;
            default: ;
        endcase
    end

    assign w_acc  = w_valid & w_ready;
    assign in_acc = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            loaded_q <= 1'b0;
            row_q    <= '0;
            drain_q  <= '0;
            cfg_q    <= '0;
            for (int r = 0; r < ROWS; r++) w_q[r] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_acc) begin
                        cfg_q.in_width     <= in_width;
                        cfg_q.weight_width <= weight_width;
                        cfg_q.s_in         <= s_in;
                        cfg_q.s_weight     <= s_weight;
                        w_q[0]             <= w_data;
                        loaded_q           <= 1'b0;
                        row_q              <= RW'(1);
                        state_q            <= LOAD_W;
                    end else if (in_acc) begin
                        drain_q <= '0;
                        state_q <= in_last ? DRAIN : STREAM;
                    end
                end
                LOAD_W: begin
                    if (w_acc) begin
                        w_q[row_q] <= w_data;
                        if (row_q == RW'(ROWS - 1)) begin
                            loaded_q <= 1'b1;
                            row_q    <= '0;
                            state_q  <= IDLE;
                        end else begin
                            row_q <= row_q + RW'(1);
                        end
                    end
                end
                STREAM: begin
                    if (in_acc && in_last) begin
                        drain_q <= '0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // ROWS+1 cycles lets the last wavefront reach the output.
                    if (drain_q == DW'(ROWS)) begin
                        drain_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        drain_q <= drain_q + DW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    input_skew #(.ROWS(ROWS)) u_skew (
        .clk        (clk),
        .rst        (rst),
        .acc_i      (in_acc),
        .last_i     (in_last),
        .data_i     (in_data),
        .row_data_o (row_data),
        .valid_o    (out_valid),
        .last_o     (out_last)
    );

    for (genvar i = 0; i < ROWS; i++) begin : g_r
        for (genvar j = 0; j < COLS; j++) begin : g_c
            logic [PSUM_W-1:0] psum_in_w;

            if (i == 0) begin : g_top
                assign psum_in_w = '0;
            end else begin : g_chain
                assign psum_in_w = psum_w[i-1][j];
            end

            fusion_unit #(.PSUM_W(PSUM_W)) u_fu (
                .clk          (clk),
                .in_data      (row_data[8*i +: 8]),
                .weight       (w_q[i][8*j +: 8]),
                .in_width     (cfg_q.in_width),
                .weight_width (cfg_q.weight_width),
                .s_in         (cfg_q.s_in),
                .s_weight     (cfg_q.s_weight),
                .psum_in      (psum_in_w),
                .psum_fwd     (psum_w[i][j])
            );
        end
    end

    // Output register on the last-row sums, aligned with the valid tail.
    always_ff @(posedge clk) begin
        for (int j = 0; j < COLS; j++) psums_q[PSUM_W*j +: PSUM_W] <= psum_w[ROWS-1][j];
    end

    assign psums = psums_q;

endmodule
